// File: rtl/prng_pkg.sv
// prng_pkg: LFSR tap masks, default seeds and arbiter FSM states
package prng_pkg;
  localparam logic [15:0] UP_TAPS = 16'hB400;
  localparam logic [7:0] DN_TAPS = 8'hB8;
  localparam logic [15:0] UP_SEED_DEF = 16'h0001;
  localparam logic [7:0] DN_SEED_DEF = 8'h01;
  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;
endpackage

// File: rtl/prng_lfsr_pair.sv
// prng_lfsr_pair: 16+8-bit LFSR pair with zero-seed substitution (load/seed_up/seed_dn load, step shifts both, rnd = up[7:0]^dn)
module prng_lfsr_pair import prng_pkg::*; #(
  parameter logic [15:0] SEED_UP_DEF = UP_SEED_DEF,
  parameter logic [7:0] SEED_DN_DEF = DN_SEED_DEF
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic step,
  input logic [15:0] seed_up,
  input logic [7:0] seed_dn,
  output logic [7:0] rnd
);
  logic [15:0] up;
  logic [7:0] dn;
  assign rnd = up[7:0] ^ dn;
  always_ff @(posedge clk) begin
    if (rst) begin
      up <= 16'h0001;
      dn <= 8'h01;
    end else if (load) begin
      up <= (seed_up == '0) ? SEED_UP_DEF : seed_up;
      dn <= (seed_dn == '0) ? SEED_DN_DEF : seed_dn;
    end else if (step) begin
      up <= {up[14:0], ^(up & UP_TAPS)};
      dn <= {dn[6:0], ^(dn & DN_TAPS)};
    end
  end
endmodule

// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin sharing of the LFSR byte source (cfg_* seed/warm-up load, req in, one-hot gnt + rnd_data out, ready in RUN)
module prng_arbiter import prng_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WARM_W = 8,
  parameter logic [15:0] SEED_UP_DEF = 16'h0001,
  parameter logic [7:0] SEED_DN_DEF = 8'h01
) (
  input logic clk,
  input logic rst,
  input logic cfg_load,
  input logic [15:0] cfg_seed_up,
  input logic [7:0] cfg_seed_dn,
  input logic [WARM_W-1:0] cfg_warmup,
  input logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [7:0] rnd_data,
  output logic ready
);
  localparam int PW = $clog2(N_REQ);
  state_t state, state_n;
  logic [WARM_W-1:0] cnt, cnt_n;
  logic [PW-1:0] ptr, pick_off, pick_idx;
  logic [PW:0] sum;
  logic [N_REQ-1:0] elig;
  logic [2*N_REQ-1:0] rot;
  logic [7:0] rnd;
  logic grant, step;
  // gnt doubles as the last-grant mask: a requester granted last cycle is not eligible now
  assign elig = req & ~gnt;
  assign grant = state == RUN && !cfg_load && |elig;
  assign step = grant || (state == WARM && !cfg_load);
  assign ready = state == RUN;
  // rotate so ptr sits at bit 0, find the first set bit, then rotate the offset back
  always_comb begin
    rot = {elig, elig} >> ptr;
    pick_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) pick_off = rot[k] ? PW'(k) : pick_off;
    sum = {1'b0, ptr} + {1'b0, pick_off};
    pick_idx = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (cfg_load) begin
      state_n = (cfg_warmup == '0) ? RUN : WARM;
      cnt_n = cfg_warmup;
    end else if (state == WARM) begin
      state_n = (cnt == WARM_W'(1)) ? RUN : WARM;
      cnt_n = cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      gnt <= '0;
      rnd_data <= 8'h00;
      ptr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gnt <= grant ? N_REQ'(1) << pick_idx : '0;
      rnd_data <= grant ? rnd : rnd_data;
      ptr <= grant ? ((pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1) : ptr;
    end
  end
  prng_lfsr_pair #(.SEED_UP_DEF(SEED_UP_DEF), .SEED_DN_DEF(SEED_DN_DEF)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .load(cfg_load),
    .step(step),
    .seed_up(cfg_seed_up),
    .seed_dn(cfg_seed_dn),
    .rnd(rnd)
  );
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: scoreboard bench for prng_arbiter against a cycle model
module tb_prng_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_load = 1'b0;
  logic [15:0] cfg_seed_up = '0;
  logic [7:0] cfg_seed_dn = '0;
  logic [7:0] cfg_warmup = '0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [7:0] rnd_data;
  logic ready;
  int total = 0;
  int bad = 0;
  typedef struct packed {logic [N-1:0] g; logic [7:0] d; logic r;} exp_t;
  exp_t sb[$];
  logic [15:0] mu = 16'h0001;
  logic [7:0] md = 8'h01;
  logic [7:0] mcnt = '0;
  int mst = 0;
  int mptr = 0;
  logic [N-1:0] mg = '0;
  logic [7:0] mdat = '0;
  logic [N-1:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  always #5 clk = ~clk;
  prng_arbiter #(.N_REQ(N), .WARM_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_load(cfg_load),
    .cfg_seed_up(cfg_seed_up),
    .cfg_seed_dn(cfg_seed_dn),
    .cfg_warmup(cfg_warmup),
    .req(req),
    .gnt(gnt),
    .rnd_data(rnd_data),
    .ready(ready)
  );
  function automatic logic [15:0] su(logic [15:0] u);
    return {u[14:0], u[15] ^ u[13] ^ u[12] ^ u[10]};
  endfunction
  function automatic logic [7:0] sd(logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // predict outputs after the coming edge from the current inputs (mst: 0 IDLE, 1 WARM, 2 RUN)
  task automatic model();
    logic [N-1:0] el;
    exp_t e;
    bit hit;
    int i;
    if (rst) begin
      mst = 0; mu = 16'h0001; md = 8'h01; mcnt = '0; mg = '0; mdat = '0; mptr = 0;
    end else if (cfg_load) begin
      mu = (cfg_seed_up == 0) ? 16'h0001 : cfg_seed_up;
      md = (cfg_seed_dn == 0) ? 8'h01 : cfg_seed_dn;
      mst = (cfg_warmup == 0) ? 2 : 1;
      mcnt = cfg_warmup;
      mg = '0;
    end else if (mst == 1) begin
      mu = su(mu); md = sd(md);
      if (mcnt == 1) mst = 2;
      mcnt--;
      mg = '0;
    end else if (mst == 2) begin
      el = req & ~mg;
      hit = 0;
      for (int k = 0; k < N; k++) begin
        i = (mptr + k) % N;
        if (!hit && el[i]) begin
          hit = 1;
          mg = '0;
          mg[i] = 1'b1;
          mdat = mu[7:0] ^ md;
          mu = su(mu); md = sd(md);
          mptr = (i + 1) % N;
        end
      end
      if (!hit) mg = '0;
    end else mg = '0;
    e.g = mg; e.d = mdat; e.r = (mst == 2);
    sb.push_back(e);
  endtask
  task automatic cyc(int n = 1);
    exp_t e;
    repeat (n) begin
      model();
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk("gnt", 32'(gnt), 32'(e.g));
      chk("rnd_data", 32'(rnd_data), 32'(e.d));
      chk("ready", 32'(ready), 32'(e.r));
    end
  endtask
  task automatic load(logic [15:0] u, logic [7:0] d, logic [7:0] w);
    cfg_load = 1'b1; cfg_seed_up = u; cfg_seed_dn = d; cfg_warmup = w;
    cyc();
    cfg_load = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    cyc(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_data", 32'(rnd_data), 0);
    chk("rst_ready", 32'(ready), 0);
    rst = 1'b0;
    req = 4'b1111;
    cyc(5);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_ready", 32'(ready), 0);
    chk("idle_data", 32'(rnd_data), 0);
    req = 4'b0001;
    load(16'hACE1, 8'h5A, 8'd0);
    chk("w0_ready", 32'(ready), 1);
    chk("w0_nognt", 32'(gnt), 0);
    cyc();
    chk("w0_g1", 32'(gnt), 1);
    chk("w0_d1", 32'(rnd_data), 32'h BB);
    cyc();
    chk("w0_gap", 32'(gnt), 0);
    cyc();
    chk("w0_g2", 32'(gnt), 1);
    chk("w0_d2", 32'(rnd_data), 32'h77);
    load(16'hACE1, 8'h5A, 8'd1);
    chk("w1_ready0", 32'(ready), 0);
    cyc();
    chk("w1_ready1", 32'(ready), 1);
    chk("w1_nognt", 32'(gnt), 0);
    cyc();
    chk("w1_g", 32'(gnt), 1);
    chk("w1_d", 32'(rnd_data), 32'h77);
    load(16'h0000, 8'h00, 8'd0);
    cyc();
    chk("zs_g", 32'(gnt), 1);
    chk("zs_d", 32'(rnd_data), 32'h00);
    cyc(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 4'b1111;
    load(16'hBEEF, 8'hC3, 8'd3);
    cyc(3);
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("rr_seq", 32'(gnt), 32'(seq[k % 4]));
    end
    load(16'h1357, 8'h9B, 8'd200);
    cyc(50);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mw_ready", 32'(ready), 0);
    chk("mw_gnt", 32'(gnt), 0);
    cyc(3);
    chk("mw_idle", 32'(ready), 0);
    load(16'h1234, 8'h56, 8'd0);
    cyc();
    chk("mw_g", 32'(gnt), 1);
    chk("mw_d", 32'(rnd_data), 32'h62);
    cyc(6);
    for (int k = 0; k < 60; k++) begin
      req = N'($urandom_range(0, 15));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
